// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: fetch/datapath control bundle between the fetch side (master) and ctrl_seq (slave)
// start/instruction/zero flow into the sequencer; enables, status and retire count flow out.
interface ctrl_seq_if #(parameter int IW = 9, parameter int CNT_W = 16);
  logic             start;
  logic [IW-1:0]    instruction;
  logic             zero;
  logic             pc_en;
  logic             reg_wr_en;
  logic             mem_wr_en;
  logic             load_inst;
  logic             branch_en;
  logic             branch_taken;
  logic             jump;
  logic [1:0]       targ_sel;
  logic             stall;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] instr_count;
  modport master (
    output start, instruction, zero,
    input  pc_en, reg_wr_en, mem_wr_en, load_inst, branch_en, branch_taken,
           jump, targ_sel, stall, busy, done, instr_count
  );
  modport slave (
    input  start, instruction, zero,
    output pc_en, reg_wr_en, mem_wr_en, load_inst, branch_en, branch_taken,
           jump, targ_sel, stall, busy, done, instr_count
  );
endinterface

// File: rtl/ctrl_seq.sv
// ctrl_seq: sequenced control decoder gating instruction enables by an IDLE/RUN/LOAD_WAIT/HALT FSM
// Ports: clk, rst_n (async active-low); bus (slave): start, instruction, zero in;
//   pc_en, reg_wr_en, mem_wr_en, load_inst, branch_en, branch_taken, jump, targ_sel,
//   stall, busy, done, instr_count out.
module ctrl_seq #(
  parameter int          IW       = 9,
  parameter logic [2:0]  LOAD_OP  = 3'b011,
  parameter logic [2:0]  STORE_OP = 3'b110,
  parameter logic [2:0]  RSH_FN   = 3'b100,
  parameter int          MEM_LAT  = 2,
  parameter int          CNT_W    = 16
) (
  input logic       clk,
  input logic       rst_n,
  ctrl_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, LOAD_WAIT, HALT} state_t;
  state_t           state, nxt;
  logic [3:0]       ctr, ctr_nx;
  logic [CNT_W-1:0] cnt;
  logic             retire, clr;
  logic             ack, st, ld, br, rw, jp;
  logic [1:0]       ts;
  assign ack = &bus.instruction;
  assign st  = bus.instruction[IW-1 -: 3] == STORE_OP;
  assign ld  = bus.instruction[IW-1 -: 3] == LOAD_OP;
  // branch class: low two bits set; bits [3:2] then pick always / zero / not-zero / never
  assign br  = &bus.instruction[1:0];
  assign rw  = bus.instruction[IW-1 -: 2] != 2'b11;
  assign jp  = bus.instruction[2:0] == RSH_FN;
  assign ts  = bus.instruction[3:2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ctr   <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      ctr   <= ctr_nx;
      cnt   <= clr ? '0 : (retire && !(&cnt)) ? cnt + 1'b1 : cnt;
    end
  always_comb begin
    nxt              = state;
    ctr_nx           = ctr;
    retire           = 1'b0;
    clr              = 1'b0;
    bus.pc_en        = 1'b0;
    bus.reg_wr_en    = 1'b0;
    bus.mem_wr_en    = 1'b0;
    bus.load_inst    = 1'b0;
    bus.branch_en    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jump         = 1'b0;
    bus.targ_sel     = 2'b00;
    bus.stall        = 1'b0;
    case (state)
      IDLE, HALT: if (bus.start) begin
        nxt = RUN;
        clr = 1'b1;
      end
      RUN: if (ack) begin
        nxt    = HALT;
        retire = 1'b1;
      end else if (ld) begin
        bus.load_inst = 1'b1;
        if (MEM_LAT == 0) begin
          bus.reg_wr_en = 1'b1;
          bus.pc_en     = 1'b1;
          retire        = 1'b1;
        end else begin
          bus.stall = 1'b1;
          ctr_nx    = 4'(MEM_LAT);
          nxt       = LOAD_WAIT;
        end
      end else begin
        bus.mem_wr_en    = st;
        bus.reg_wr_en    = rw;
        bus.jump         = jp;
        bus.branch_en    = br;
        bus.targ_sel     = ts;
        bus.branch_taken = br & ((ts == 2'b00) | ((ts == 2'b01) & bus.zero) | ((ts == 2'b10) & ~bus.zero));
        bus.pc_en        = 1'b1;
        retire           = 1'b1;
      end
      LOAD_WAIT: begin
        bus.load_inst = 1'b1;
        if (ctr == 4'd1) begin
          bus.reg_wr_en = 1'b1;
          bus.pc_en     = 1'b1;
          retire        = 1'b1;
          ctr_nx        = '0;
          nxt           = RUN;
        end else begin
          bus.stall = 1'b1;
          ctr_nx    = ctr - 4'd1;
        end
      end
      default: nxt = IDLE;
    endcase
  end
  assign bus.busy        = (state == RUN) || (state == LOAD_WAIT);
  assign bus.done        = state == HALT;
  assign bus.instr_count = cnt;
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed scoreboard bench for ctrl_seq (MEM_LAT=2, CNT_W=3 to reach saturation)
module tb_ctrl_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ctrl_seq_if #(.IW(9), .CNT_W(3)) bus ();
  ctrl_seq #(.IW(9), .LOAD_OP(3'b011), .STORE_OP(3'b110), .RSH_FN(3'b100), .MEM_LAT(2), .CNT_W(3))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    string      name;
    logic [15:0] v;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] act;
  assign act = {bus.pc_en, bus.reg_wr_en, bus.mem_wr_en, bus.load_inst, bus.branch_en,
                bus.branch_taken, bus.jump, bus.targ_sel, bus.stall, bus.busy, bus.done,
                bus.instr_count};
  function automatic logic [15:0] ev(bit pc, bit rw, bit mw, bit li, bit be, bit bt, bit jp,
                                     logic [1:0] ts, bit st, bit bu, bit dn, logic [2:0] c);
    return {pc, rw, mw, li, be, bt, jp, ts, st, bu, dn, c};
  endfunction
  task automatic step(input string name, input bit rn, input bit s, input logic [8:0] ins,
                      input bit z, input logic [15:0] e);
    exp_t it;
    @(posedge clk);
    #1;
    rst_n = rn;
    bus.start = s;
    bus.instruction = ins;
    bus.zero = z;
    it.name = name;
    it.v = e;
    q.push_back(it);
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t it;
      it = q.pop_front();
      checks++;
      if (act !== it.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b (pc rw mw li be bt jp ts2 st bu dn cnt3)", it.name, act, it.v);
      end
    end
  localparam logic [15:0] Z = 16'h0000;
  initial begin
    bus.start = 1'b0;
    bus.instruction = 9'h1FF;
    bus.zero = 1'b0;
    step("reset", 0, 0, 9'h1FF, 0, Z);
    for (int i = 0; i < 10; i++) step("idle", 1, 0, 9'h1FF, 0, Z);
    step("start", 1, 1, 9'h005, 0, Z);
    step("alu", 1, 0, 9'h005, 0, ev(1,1,0,0,0,0,0,2'b01,0,1,0,3'd0));
    step("store", 1, 0, 9'h180, 0, ev(1,0,1,0,0,0,0,2'b00,0,1,0,3'd1));
    step("ack", 1, 0, 9'h1FF, 0, ev(0,0,0,0,0,0,0,2'b00,0,1,0,3'd2));
    step("halt", 1, 0, 9'h000, 0, ev(0,0,0,0,0,0,0,2'b00,0,0,1,3'd3));
    step("halt2", 1, 0, 9'h000, 0, ev(0,0,0,0,0,0,0,2'b00,0,0,1,3'd3));
    step("restart", 1, 1, 9'h0C0, 0, ev(0,0,0,0,0,0,0,2'b00,0,0,1,3'd3));
    step("load1", 1, 0, 9'h0C0, 0, ev(0,0,0,1,0,0,0,2'b00,1,1,0,3'd0));
    step("load2", 1, 0, 9'h0C0, 0, ev(0,0,0,1,0,0,0,2'b00,1,1,0,3'd0));
    step("load3", 1, 0, 9'h0C0, 0, ev(1,1,0,1,0,0,0,2'b00,0,1,0,3'd0));
    step("jump", 1, 0, 9'h004, 0, ev(1,1,0,0,0,0,1,2'b01,0,1,0,3'd1));
    step("br_never", 1, 0, 9'h00F, 1, ev(1,1,0,0,1,0,0,2'b11,0,1,0,3'd2));
    step("br_z1", 1, 0, 9'h007, 1, ev(1,1,0,0,1,1,0,2'b01,0,1,0,3'd3));
    step("br_z0", 1, 0, 9'h007, 0, ev(1,1,0,0,1,0,0,2'b01,0,1,0,3'd4));
    step("br_nz", 1, 0, 9'h00B, 0, ev(1,1,0,0,1,1,0,2'b10,0,1,0,3'd5));
    step("br_always", 1, 0, 9'h003, 1, ev(1,1,0,0,1,1,0,2'b00,0,1,0,3'd6));
    step("cnt7", 1, 0, 9'h000, 0, ev(1,1,0,0,0,0,0,2'b00,0,1,0,3'd7));
    step("sat1", 1, 0, 9'h000, 0, ev(1,1,0,0,0,0,0,2'b00,0,1,0,3'd7));
    step("sat2", 1, 1, 9'h000, 0, ev(1,1,0,0,0,0,0,2'b00,0,1,0,3'd7));
    step("ack_sat", 1, 0, 9'h1FF, 0, ev(0,0,0,0,0,0,0,2'b00,0,1,0,3'd7));
    step("halt_sat", 1, 0, 9'h000, 0, ev(0,0,0,0,0,0,0,2'b00,0,0,1,3'd7));
    step("restart2", 1, 1, 9'h000, 0, ev(0,0,0,0,0,0,0,2'b00,0,0,1,3'd7));
    step("cleared", 1, 0, 9'h000, 0, ev(1,1,0,0,0,0,0,2'b00,0,1,0,3'd0));
    step("ld_a", 1, 0, 9'h0C0, 0, ev(0,0,0,1,0,0,0,2'b00,1,1,0,3'd1));
    step("ld_b", 1, 0, 9'h0C0, 0, ev(0,0,0,1,0,0,0,2'b00,1,1,0,3'd1));
    step("async_rst", 0, 0, 9'h0C0, 0, Z);
    step("rst_hold", 0, 0, 9'h0C0, 0, Z);
    step("post_rst", 1, 0, 9'h005, 0, Z);
    step("start3", 1, 1, 9'h005, 0, Z);
    step("store3", 1, 0, 9'h180, 0, ev(1,0,1,0,0,0,0,2'b00,0,1,0,3'd0));
    step("ack3", 1, 0, 9'h1FF, 0, ev(0,0,0,0,0,0,0,2'b00,0,1,0,3'd1));
    step("halt3", 1, 0, 9'h000, 0, ev(0,0,0,0,0,0,0,2'b00,0,0,1,3'd2));
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
